// File: rtl/axis_video_pos_slice.sv
// AXI4-Stream video register slice: 2-entry skid buffer, per-pixel column/row tags, geometry checks.
// Optional per-frame error counter output enabled by defining POS_SLICE_ERR_CNT_EN.
module axis_video_pos_slice #(
  parameter int DATA_W      = 24,
  parameter int ACTIVE_COLS = 1280,
  parameter int ACTIVE_ROWS = 720,
  parameter int COORD_W     = 12
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               aclken,
  input  logic [DATA_W-1:0]  s_axis_video_tdata_in,
  input  logic               s_axis_video_tvalid_in,
  input  logic               s_axis_video_tuser_in,
  input  logic               s_axis_video_tlast_in,
  output logic               s_axis_video_tready_out,
  output logic [DATA_W-1:0]  m_axis_video_tdata_out,
  output logic               m_axis_video_tvalid_out,
  output logic               m_axis_video_tuser_out,
  output logic               m_axis_video_tlast_out,
  input  logic               m_axis_video_tready_in,
  output logic [COORD_W-1:0] pix_col_out,
  output logic [COORD_W-1:0] pix_row_out,
  output logic               frame_done_out,
  output logic               err_early_eol_out,
  output logic               err_late_eol_out,
  output logic               err_rows_out
`ifdef POS_SLICE_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt_out
`endif
);

  localparam int BW = DATA_W + 2 + 2*COORD_W;
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(ACTIVE_COLS - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(ACTIVE_ROWS - 1);
  localparam logic [COORD_W:0]   NUM_ROWS = (COORD_W+1)'(ACTIVE_ROWS);

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (&v) ? v : v + COORD_W'(1);
  endfunction

  // Beat layout: {data, user, last, col, row}
  logic [BW-1:0]      main_q, main_d, skid_q, skid_d, beat;
  logic               main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic               tready_q, tready_d;
  logic [COORD_W-1:0] col_q, col_d, row_q, row_d, beat_col, beat_row;
  logic               first_q, first_d;
  logic               early_q, early_d, late_q, late_d, rows_q, rows_d;
  logic               in_acc, out_acc, main_free, rows_cond;

  assign in_acc    = s_axis_video_tvalid_in & tready_q & aclken;
  assign out_acc   = main_vld_q & m_axis_video_tready_in & aclken;
  assign main_free = ~main_vld_q | out_acc;
  assign beat_col  = s_axis_video_tuser_in ? '0 : col_q;
  assign beat_row  = s_axis_video_tuser_in ? '0 : row_q;
  assign beat      = {s_axis_video_tdata_in, s_axis_video_tuser_in, s_axis_video_tlast_in,
                      beat_col, beat_row};
  assign rows_cond = ({1'b0, row_q} != NUM_ROWS) & ~first_q;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    col_d      = col_q;
    row_d      = row_q;
    first_d    = first_q;
    early_d    = early_q;
    late_d     = late_q;
    rows_d     = rows_q;

    if (out_acc && skid_vld_q) begin
      main_d     = skid_q;
      main_vld_d = 1'b1;
      skid_vld_d = 1'b0;
    end else if (in_acc && main_free) begin
      main_d     = beat;
      main_vld_d = 1'b1;
    end else if (out_acc) begin
      main_vld_d = 1'b0;
    end
    if (in_acc && !main_free) begin
      skid_d     = beat;
      skid_vld_d = 1'b1;
    end

    if (in_acc) begin
      // A new frame clears the sticky flags, but a fault seen on this very beat still sets them.
      if (s_axis_video_tuser_in) begin
        early_d = 1'b0;
        late_d  = 1'b0;
        rows_d  = rows_cond;
        first_d = 1'b0;
      end
      if (s_axis_video_tlast_in && (beat_col != LAST_COL)) early_d = 1'b1;
      if (!s_axis_video_tlast_in && (beat_col == LAST_COL)) late_d = 1'b1;
      if (s_axis_video_tlast_in) begin
        col_d = '0;
        row_d = sat_inc(beat_row);
      end else begin
        col_d = sat_inc(beat_col);
        row_d = beat_row;
      end
    end

    tready_d = aclken ? ~skid_vld_d : tready_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      tready_q   <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      first_q    <= 1'b1;
      early_q    <= 1'b0;
      late_q     <= 1'b0;
      rows_q     <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      tready_q   <= tready_d;
      col_q      <= col_d;
      row_q      <= row_d;
      first_q    <= first_d;
      early_q    <= early_d;
      late_q     <= late_d;
      rows_q     <= rows_d;
    end
  end

  assign s_axis_video_tready_out = tready_q;
  assign m_axis_video_tvalid_out = main_vld_q;
  assign m_axis_video_tdata_out  = main_q[BW-1 -: DATA_W];
  assign m_axis_video_tuser_out  = main_q[2*COORD_W+1];
  assign m_axis_video_tlast_out  = main_q[2*COORD_W];
  assign pix_col_out             = main_q[2*COORD_W-1 -: COORD_W];
  assign pix_row_out             = main_q[COORD_W-1:0];
  assign frame_done_out          = out_acc & m_axis_video_tlast_out & (pix_row_out == LAST_ROW);
  assign err_early_eol_out       = early_q;
  assign err_late_eol_out        = late_q;
  assign err_rows_out            = rows_q;

`ifdef POS_SLICE_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        counted_q, counted_d;
  logic        frame_end, frame_bad;

  // A frame ends at frame_done or at the next tuser; counted_q stops one frame being counted twice.
  assign frame_end = (in_acc & s_axis_video_tuser_in) | frame_done_out;
  assign frame_bad = early_q | late_q | rows_q | (in_acc & s_axis_video_tuser_in & rows_cond);

  always_comb begin
    err_cnt_d = err_cnt_q;
    counted_d = counted_q;
    if (frame_end && frame_bad && !counted_q && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
    if (in_acc && s_axis_video_tuser_in) counted_d = 1'b0;
    else if (frame_end && frame_bad)     counted_d = 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_cnt_q <= '0;
      counted_q <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      counted_q <= counted_d;
    end
  end

  assign err_cnt_out = err_cnt_q;
`endif

endmodule

// File: tb/tb_axis_video_pos_slice.sv
// Bench for axis_video_pos_slice: directed vector table, reset checks, randomized frames vs. scoreboard model.
module tb_axis_video_pos_slice;
  localparam int DW   = 16;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk, rst, en;
  logic [DW-1:0] s_d;
  logic          s_v, s_u, s_l, s_r;
  logic [DW-1:0] m_d;
  logic          m_v, m_u, m_l, m_r;
  logic [CW-1:0] col, row;
  logic          fdone, e_early, e_late, e_rows;

  axis_video_pos_slice #(.DATA_W(DW), .ACTIVE_COLS(COLS), .ACTIVE_ROWS(ROWS), .COORD_W(CW)) dut (
    .aclk(clk), .areset(rst), .aclken(en),
    .s_axis_video_tdata_in(s_d), .s_axis_video_tvalid_in(s_v),
    .s_axis_video_tuser_in(s_u), .s_axis_video_tlast_in(s_l),
    .s_axis_video_tready_out(s_r),
    .m_axis_video_tdata_out(m_d), .m_axis_video_tvalid_out(m_v),
    .m_axis_video_tuser_out(m_u), .m_axis_video_tlast_out(m_l),
    .m_axis_video_tready_in(m_r),
    .pix_col_out(col), .pix_row_out(row), .frame_done_out(fdone),
    .err_early_eol_out(e_early), .err_late_eol_out(e_late), .err_rows_out(e_rows)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic vld, usr, lst, rdy;
    logic [DW-1:0] d;
    logic e_rdy, e_vld, e_lst, e_early;
    logic [DW-1:0] e_d;
    int e_col, e_row;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic usr, input logic lst, input logic rdy,
                              input logic [DW-1:0] d, input logic e_rdy, input logic e_vld,
                              input logic [DW-1:0] e_d, input int e_col, input int e_row,
                              input logic e_lst, input logic e_early);
    vec_t v;
    v.vld = vld; v.usr = usr; v.lst = lst; v.rdy = rdy; v.d = d;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_d = e_d; v.e_col = e_col; v.e_row = e_row;
    v.e_lst = e_lst; v.e_early = e_early;
    return v;
  endfunction

  typedef struct packed { logic [DW-1:0] d; logic u; logic l; } src_t;
  typedef struct { logic [DW-1:0] d; logic u; logic l; int col; int row; } beat_t;

  src_t  src[$];
  beat_t sb[$];

  // Reference model state
  int mcol, mrow;
  bit mfirst, mearly, mlate, mrows;
  bit mon_en = 0;
  int mode = 0;
  bit src_done = 0;
  bit prev_trdy, prev_rdy, prev_en, prev_in_acc;

  task automatic add_line(input int len, input bit sof, input bit eol);
    src_t s;
    for (int k = 0; k < len; k++) begin
      s.d = DW'($urandom);
      s.u = sof && (k == 0);
      s.l = eol && (k == len - 1);
      src.push_back(s);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      beat_t e;
      int bcol, brow;
      if (m_v && m_r && en) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_underflow: got unexpected output beat %0h, expected none", m_d);
        end else begin
          e = sb.pop_front();
          chk("out_data", m_d, e.d);
          chk("out_user", m_u, e.u);
          chk("out_last", m_l, e.l);
          chk("out_col", col, e.col);
          chk("out_row", row, e.row);
          chk("frame_done", fdone, e.l && (e.row == ROWS - 1));
        end
      end else begin
        chk("frame_done_idle", fdone, 0);
      end
      chk("err_early", e_early, mearly);
      chk("err_late", e_late, mlate);
      chk("err_rows", e_rows, mrows);
      if (!prev_trdy && prev_rdy && prev_en) chk("tready_recover", s_r, 1);
      if (prev_in_acc) chk("latency", m_v, 1);
      if (mode == 0) chk("full_rate_tready", s_r, 1);

      prev_in_acc = s_v && s_r && en;
      if (prev_in_acc) begin
        bcol = s_u ? 0 : mcol;
        brow = s_u ? 0 : mrow;
        if (s_u) begin
          mrows  = (mrow != ROWS) && !mfirst;
          mearly = 0;
          mlate  = 0;
          mfirst = 0;
        end
        if (s_l && bcol != COLS - 1) mearly = 1;
        if (!s_l && bcol == COLS - 1) mlate = 1;
        if (s_l) begin
          mcol = 0;
          mrow = (brow + 1 > MAXC) ? MAXC : brow + 1;
        end else begin
          mcol = (bcol + 1 > MAXC) ? MAXC : bcol + 1;
          mrow = brow;
        end
        e.d = s_d; e.u = s_u; e.l = s_l; e.col = bcol; e.row = brow;
        sb.push_back(e);
      end
      prev_trdy = s_r;
      prev_rdy  = m_r;
      prev_en   = en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int n_a, n_b;
    tbl[0] = mk(1, 1, 0, 1, 16'hA000, 1, 0, 16'h0,    0, 0, 0, 0);
    tbl[1] = mk(1, 0, 0, 0, 16'hA001, 1, 1, 16'hA000, 0, 0, 0, 0);
    tbl[2] = mk(1, 0, 0, 0, 16'hA002, 0, 1, 16'hA000, 0, 0, 0, 0);
    tbl[3] = mk(1, 0, 0, 1, 16'hA002, 0, 1, 16'hA000, 0, 0, 0, 0);
    tbl[4] = mk(1, 0, 0, 1, 16'hA002, 1, 1, 16'hA001, 1, 0, 0, 0);
    tbl[5] = mk(0, 0, 0, 0, 16'h0,    1, 1, 16'hA002, 2, 0, 0, 0);
    tbl[6] = mk(1, 0, 1, 1, 16'hA003, 1, 1, 16'hA002, 2, 0, 0, 0);
    tbl[7] = mk(1, 0, 0, 1, 16'hA004, 1, 1, 16'hA003, 3, 0, 1, 1);
    tbl[8] = mk(0, 0, 0, 1, 16'h0,    1, 1, 16'hA004, 0, 1, 0, 1);
    tbl[9] = mk(0, 0, 0, 1, 16'h0,    1, 0, 16'h0,    0, 0, 0, 1);

    rst = 0; en = 1; s_v = 0; s_u = 0; s_l = 0; s_d = '0; m_r = 0;
    #2 rst = 1;
    @(negedge clk);
    chk("rst_tready", s_r, 0);
    chk("rst_tvalid", m_v, 0);
    chk("rst_data", m_d, 0);
    chk("rst_flags", {e_early, e_late, e_rows, fdone}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_tready", s_r, 1);
    chk("post_rst_tvalid", m_v, 0);

    for (int i = 0; i < 10; i++) begin
      s_v = tbl[i].vld; s_u = tbl[i].usr; s_l = tbl[i].lst; s_d = tbl[i].d; m_r = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_tready", i), s_r, tbl[i].e_rdy);
      chk($sformatf("vec%0d_tvalid", i), m_v, tbl[i].e_vld);
      chk($sformatf("vec%0d_early", i), e_early, tbl[i].e_early);
      if (tbl[i].e_vld) begin
        chk($sformatf("vec%0d_data", i), m_d, tbl[i].e_d);
        chk($sformatf("vec%0d_col", i), col, tbl[i].e_col);
        chk($sformatf("vec%0d_row", i), row, tbl[i].e_row);
        chk($sformatf("vec%0d_last", i), m_l, tbl[i].e_lst);
      end
      @(posedge clk); #1;
    end

    // Fill main and skid, then reset with both occupied.
    s_v = 1; s_u = 0; s_l = 0; s_d = 16'h5555; m_r = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("prefill_full", {m_v, s_r}, 2'b10);
    rst = 1; s_v = 0;
    #1;
    chk("midrst_tready", s_r, 0);
    chk("midrst_tvalid", m_v, 0);
    chk("midrst_data", m_d, 0);
    chk("midrst_coords", {col, row}, 0);
    chk("midrst_flags", {e_early, e_late, e_rows}, 0);
    #2 rst = 0;
    @(posedge clk); #1;
    chk("midrst_release_tready", s_r, 1);
    chk("midrst_release_tvalid", m_v, 0);

    for (int f = 0; f < 2; f++) for (int j = 0; j < 4; j++) add_line(8, j == 0, 1);
    n_a = src.size();
    add_line(8, 1, 1); add_line(5, 0, 1); add_line(8, 0, 1); add_line(8, 0, 1);
    add_line(8, 1, 1); add_line(10, 0, 1); add_line(20, 0, 1); add_line(8, 0, 1);
    n_b = src.size();
    for (int j = 0; j < 3; j++) add_line(8, j == 0, 1);
    for (int j = 0; j < 4; j++) add_line(8, j == 0, 1);
    for (int j = 0; j < 6; j++) add_line(8, j == 0, 1);
    add_line(1, 1, 0);

    mcol = 0; mrow = 0; mfirst = 1; mearly = 0; mlate = 0; mrows = 0;
    prev_trdy = 1; prev_rdy = 0; prev_en = 1; prev_in_acc = 0;
    m_r = 1; en = 1; mode = 0;
    mon_en = 1;

    fork
      begin
        bit acc;
        for (int i = 0; i < src.size(); i++) begin
          mode = (i < n_a) ? 0 : (i < n_b) ? 1 : 2;
          do begin
            s_v = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
            s_d = src[i].d; s_u = src[i].u; s_l = src[i].l;
            @(negedge clk);
            acc = s_v && s_r && en;
            @(posedge clk); #1;
          end while (!acc);
        end
        s_v = 0;
        src_done = 1;
      end
      begin
        bit tog = 1;
        while (!src_done) begin
          @(posedge clk); #1;
          if (mode == 0) begin
            m_r = 1; en = 1;
          end else if (mode == 1) begin
            m_r = tog; tog = ~tog; en = 1;
          end else begin
            m_r = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) != 0);
          end
        end
      end
    join

    m_r = 1; en = 1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain_empty", sb.size(), 0);
    mon_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
